// File: rtl/booth_pkg.sv
// Shared types for the radix-2 Booth multiplier controller.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {NOP, ADD, SUB}   op_t;

  localparam int WIDTH_DEF = 4;

  // Counter must hold WIDTH itself, hence +1.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/booth_recode.sv
// Radix-2 Booth recoder: {q0, q_m1} -> add/sub/nop.
import booth_pkg::*;

module booth_recode (
  input  logic q0,
  input  logic q_m1,
  output op_t  op
);

  always_comb begin
    op = NOP;
    unique case ({q0, q_m1})
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase
  end

endmodule

// File: rtl/booth_mul_ctrl.sv
// Sequential Booth multiplier controller driving an external ripple add/sub unit.
import booth_pkg::*;

module booth_mul_ctrl #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   as_a,
  output logic [WIDTH-1:0]   as_b,
  output logic               as_sub,
  input  logic [WIDTH-1:0]   as_sum,
  input  logic               as_cout
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state, state_d;
  op_t              op;
  logic [WIDTH-1:0] acc, q, m;
  logic             q_m1;
  logic [CW-1:0]    count;
  logic             sx;
  logic             last;

  booth_recode u_recode (.q0(q[0]), .q_m1(q_m1), .op(op));

  assign as_a   = acc;
  assign as_b   = (op != NOP) ? m : '0;
  assign as_sub = (op == SUB);
  // Bit W of the true (W+1)-bit sum; as_sum[W-1] is wrong when M = -2^(W-1).
  assign sx     = as_a[WIDTH-1] ^ (as_b[WIDTH-1] ^ as_sub) ^ as_cout;
  assign last   = (count == CW'(1));

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      m       <= '0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m     <= multiplicand;
            q     <= multiplier;
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= CW'(WIDTH);
            busy  <= 1'b1;
          end
        end
        RUN: begin
          acc   <= {sx, as_sum[WIDTH-1:1]};
          q     <= {as_sum[0], q[WIDTH-1:1]};
          q_m1  <= q[0];
          count <= count - CW'(1);
          if (last) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= {sx, as_sum, q[WIDTH-1:1]};
          end
        end
        DONE:    done <= 1'b0;
        default: done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Scoreboard bench for booth_mul_ctrl with a behavioural add/sub unit in the loop.
module tb_booth_mul_ctrl;

  localparam int W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [W-1:0]     multiplicand = '0, multiplier = '0;
  logic             busy, done;
  logic [2*W-1:0]   product;
  logic [W-1:0]     as_a, as_b, as_sum;
  logic             as_sub, as_cout;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_exp;

  always #5 clk = ~clk;

  booth_mul_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product),
    .as_a(as_a), .as_b(as_b), .as_sub(as_sub),
    .as_sum(as_sum), .as_cout(as_cout)
  );

  // Ripple add/sub unit: A + (B ^ {s}) + s.
  logic [W:0] as_full;
  assign as_full = {1'b0, as_a} + {1'b0, as_b ^ {W{as_sub}}} + {{W{1'b0}}, as_sub};
  assign as_sum  = as_full[W-1:0];
  assign as_cout = as_full[W];

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[2*W-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expected product.
  always @(negedge clk) begin
    if (rst_n && done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: product %0h with empty scoreboard", product);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        if (product !== e) begin
          bad++;
          $display("FAIL product: got %0h want %0h", product, e);
        end
      end
    end
  end

  // Issue one multiply; returns the product seen on done. hold keeps start high through RUN/DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                        output logic [2*W-1:0] got);
    int n;
    bit busy_bad;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    exp_q.push_back(ref_mul(a, b));
    last_exp = ref_mul(a, b);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    n = 0;
    busy_bad = 1'b0;
    while (!done && n < 3 * W) begin
      if (!busy) busy_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    got = product;
    check("latency", n, W);
    check("busy_during_run", busy_bad, 0);
    check("busy_at_done", busy, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("no_restart_in_done", busy, 0);
    start = 1'b0;
  endtask

  logic [2*W-1:0] got;
  logic [W-1:0]   dm[10] = '{4'd3, 4'hD, 4'h8, 4'h8, 4'd7, 4'd0, 4'hB, 4'd5, 4'hF, 4'd1};
  logic [W-1:0]   dq[10] = '{4'd2, 4'd2, 4'h8, 4'd7, 4'h8, 4'hB, 4'd1, 4'd3, 4'hF, 4'h8};
  logic [2*W-1:0] dp[10] = '{8'h06, 8'hFA, 8'h40, 8'hC8, 8'hC8, 8'h00, 8'hFB, 8'h0F, 8'h01, 8'hF8};

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    check("rst_as_a", as_a, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(dm[i], dq[i], i[0], got);
      check($sformatf("directed_%0d", i), got, dp[i]);
    end

    repeat (3) @(posedge clk);
    #1 check("product_hold", product, last_exp);

    // Abort mid-operation.
    @(negedge clk);
    multiplicand = 4'd7; multiplier = 4'd6; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_product", product, 0);
    @(negedge clk); rst_n = 1'b1;
    run_op(4'd5, 4'd3, 1'b0, got);
    check("after_abort", got, 8'h0F);

    // Exhaustive sweep.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(W'(a), W'(b), 1'b0, got);

    // Random operands and idle gaps.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_op(W'($urandom), W'($urandom), bit'($urandom_range(0, 1)), got);
    end

    repeat (2) @(posedge clk);
    #1 check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
